// File: rtl/kapisma_turnuva.sv
// Multi-round, N-player grid-guess contest: per-round winner and score,
// saturating game total, per-player win counts and champion selection.
module kapisma_turnuva #(
    parameter int OYUNCU_SAYISI = 3,
    parameter int IZGARA_BIT    = 2,
    parameter int TUR_SAYISI    = 4,
    parameter int PUAN_W        = 8,
    parameter int ONCELIK_MODU  = 1
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic                                       basla,
    input  logic                                       tur_gecerli,
    output logic                                       tur_hazir,
    input  logic [OYUNCU_SAYISI*IZGARA_BIT-1:0]        sag_adimlar,
    input  logic [OYUNCU_SAYISI*IZGARA_BIT-1:0]        asagi_adimlar,
    input  logic [2*IZGARA_BIT-1:0]                    sayi,
    output logic                                       tur_sonuc_gecerli,
    output logic [$clog2(OYUNCU_SAYISI+1)-1:0]         tur_kazanan,
    output logic [2*IZGARA_BIT+$clog2(OYUNCU_SAYISI)-1:0] tur_puan,
    output logic [PUAN_W-1:0]                          toplam_puan,
    output logic [$clog2(OYUNCU_SAYISI+1)-1:0]         sampiyon,
    output logic                                       bitti
);

    localparam int N  = OYUNCU_SAYISI;
    localparam int G  = IZGARA_BIT;
    localparam int KW = $clog2(N + 1);
    localparam int PW = 2 * G + $clog2(N);
    localparam int WW = $clog2(TUR_SAYISI + 1);
    localparam int SW = ((PW > PUAN_W) ? PW : PUAN_W) + 1;

    typedef enum logic [2:0] {BOSTA, OYUN, HESAPLA, SONUC, BITTI} durum_t;

    durum_t          durum;
    logic [N*G-1:0]  sag_r;
    logic [N*G-1:0]  asagi_r;
    logic [2*G-1:0]  sayi_r;
    logic [WW-1:0]   tur_sayac;
    logic [WW-1:0]   galibiyet [N];

    logic [N-1:0]    dogru;
    logic [2*G-1:0]  tahmin;
    logic [PW-1:0]   p_top;
    logic [PW-1:0]   q_top;
    logic [PW-1:0]   tur_puan_n;
    logic [KW-1:0]   kazanan;
    logic [KW-1:0]   sampiyon_n;
    logic [WW-1:0]   en_cok;
    logic [SW-1:0]   toplam_gen;
    logic [PUAN_W-1:0] toplam_n;

    // Priority position p -> 0-based player index.
    function automatic int sira(input int p);
        if (ONCELIK_MODU == 0 || p == 0) return p;
        return N - p;
    endfunction

    always_comb begin
        dogru  = '0;
        tahmin = '0;
        p_top  = '0;
        q_top  = '0;
        for (int i = 0; i < N; i++) begin
            tahmin = {asagi_r[(N-1-i)*G +: G], sag_r[(N-1-i)*G +: G]};
            dogru[i] = (tahmin == sayi_r);
            if (dogru[i]) p_top = p_top + PW'(tahmin);
            else          q_top = q_top + PW'(tahmin);
        end
        tur_puan_n = (p_top > q_top) ? p_top - q_top : '0;
    end

    // Walk the order backwards so the highest-priority hit is written last.
    always_comb begin
        kazanan = '0;
        for (int p = N - 1; p >= 0; p--)
            if (dogru[sira(p)]) kazanan = KW'(sira(p) + 1);
    end

    always_comb begin
        en_cok     = '0;
        sampiyon_n = '0;
        for (int p = 0; p < N; p++) begin
            if (galibiyet[sira(p)] > en_cok) begin
                en_cok     = galibiyet[sira(p)];
                sampiyon_n = KW'(sira(p) + 1);
            end
        end
    end

    assign toplam_gen = SW'(toplam_puan) + SW'(tur_puan_n);
    assign toplam_n   = (toplam_gen > SW'({PUAN_W{1'b1}})) ?
                        {PUAN_W{1'b1}} : toplam_gen[PUAN_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            durum             <= BOSTA;
            tur_hazir         <= 1'b0;
            tur_sonuc_gecerli <= 1'b0;
            tur_kazanan       <= '0;
            tur_puan          <= '0;
            toplam_puan       <= '0;
            sampiyon          <= '0;
            bitti             <= 1'b0;
            sag_r             <= '0;
            asagi_r           <= '0;
            sayi_r            <= '0;
            tur_sayac         <= '0;
            for (int i = 0; i < N; i++) galibiyet[i] <= '0;
        end else begin
            tur_sonuc_gecerli <= 1'b0;
            unique case (durum)
                BOSTA, BITTI: begin
                    if (basla) begin
                        durum       <= OYUN;
                        tur_hazir   <= 1'b1;
                        tur_kazanan <= '0;
                        tur_puan    <= '0;
                        toplam_puan <= '0;
                        sampiyon    <= '0;
                        bitti       <= 1'b0;
                        tur_sayac   <= '0;
                        for (int i = 0; i < N; i++) galibiyet[i] <= '0;
                    end
                end
                OYUN: begin
                    if (tur_gecerli) begin
                        sag_r     <= sag_adimlar;
                        asagi_r   <= asagi_adimlar;
                        sayi_r    <= sayi;
                        tur_hazir <= 1'b0;
                        durum     <= HESAPLA;
                    end
                end
                HESAPLA: begin
                    tur_kazanan       <= kazanan;
                    tur_puan          <= tur_puan_n;
                    toplam_puan       <= toplam_n;
                    tur_sonuc_gecerli <= 1'b1;
                    tur_sayac         <= tur_sayac + WW'(1);
                    for (int i = 0; i < N; i++)
                        if (kazanan == KW'(i + 1))
                            galibiyet[i] <= galibiyet[i] + WW'(1);
                    if (tur_sayac == WW'(TUR_SAYISI - 1)) begin
                        durum <= SONUC;
                    end else begin
                        durum     <= OYUN;
                        tur_hazir <= 1'b1;
                    end
                end
                SONUC: begin
                    sampiyon <= sampiyon_n;
                    bitti    <= 1'b1;
                    durum    <= BITTI;
                end
                default: durum <= BOSTA;
            endcase
        end
    end

endmodule

// File: tb/tb_kapisma_turnuva.sv
// Bench for kapisma_turnuva: default instance plus a PUAN_W=4, mode-0
// instance driven in parallel, table vectors and randomized games.
module tb_kapisma_turnuva;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        basla = 1'b0;
    logic        tur_gecerli = 1'b0;
    logic [5:0]  sag_adimlar = '0;
    logic [5:0]  asagi_adimlar = '0;
    logic [3:0]  sayi = '0;

    logic        hazir0, hazir1, sg0, sg1, bitti0, bitti1;
    logic [1:0]  kaz0, kaz1, samp0, samp1;
    logic [5:0]  puan0, puan1;
    logic [7:0]  top0;
    logic [3:0]  top1;

    int errors = 0;
    int checks = 0;

    int tot [2];
    int wins [2][3];
    int mode [2] = '{1, 0};
    int cap [2] = '{255, 15};
    int rounds;

    typedef struct {
        logic [11:0] gs;
        logic [3:0]  s;
        int k0, p, t0, k1, t1;
    } vec_t;
    vec_t tbl [4];

    always #5 clk = ~clk;

    kapisma_turnuva d0 (
        .clk(clk), .rst_n(rst_n), .basla(basla), .tur_gecerli(tur_gecerli),
        .tur_hazir(hazir0), .sag_adimlar(sag_adimlar),
        .asagi_adimlar(asagi_adimlar), .sayi(sayi),
        .tur_sonuc_gecerli(sg0), .tur_kazanan(kaz0), .tur_puan(puan0),
        .toplam_puan(top0), .sampiyon(samp0), .bitti(bitti0)
    );

    kapisma_turnuva #(.PUAN_W(4), .ONCELIK_MODU(0)) d1 (
        .clk(clk), .rst_n(rst_n), .basla(basla), .tur_gecerli(tur_gecerli),
        .tur_hazir(hazir1), .sag_adimlar(sag_adimlar),
        .asagi_adimlar(asagi_adimlar), .sayi(sayi),
        .tur_sonuc_gecerli(sg1), .tur_kazanan(kaz1), .tur_puan(puan1),
        .toplam_puan(top1), .sampiyon(samp1), .bitti(bitti1)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int order_of(input int m, input int k);
        int ord[$];
        ord.push_back(1);
        if (m == 0) for (int i = 2; i <= 3; i++) ord.push_back(i);
        else        for (int i = 3; i >= 2; i--) ord.push_back(i);
        return ord[k];
    endfunction

    function automatic int guess(input logic [11:0] gs, input int pl);
        return int'(gs[(3-pl)*4 +: 4]);
    endfunction

    function automatic int mwin(input int m, input logic [11:0] gs,
                                input int s);
        for (int k = 0; k < 3; k++)
            if (guess(gs, order_of(m, k)) == s) return order_of(m, k);
        return 0;
    endfunction

    function automatic int mscore(input logic [11:0] gs, input int s);
        int p = 0, q = 0;
        for (int pl = 1; pl <= 3; pl++)
            if (guess(gs, pl) == s) p += guess(gs, pl);
            else                    q += guess(gs, pl);
        return (p > q) ? p - q : 0;
    endfunction

    function automatic int mchamp(input int d);
        int best = 0, c = 0;
        for (int k = 0; k < 3; k++) begin
            int pl = order_of(mode[d], k);
            if (wins[d][pl-1] > best) begin
                best = wins[d][pl-1];
                c = pl;
            end
        end
        return c;
    endfunction

    task automatic start();
        basla = 1'b1;
        step();
        basla = 1'b0;
        rounds = 0;
        for (int d = 0; d < 2; d++) begin
            tot[d] = 0;
            for (int i = 0; i < 3; i++) wins[d][i] = 0;
        end
        chk("hazir_start0", hazir0, 1);
        chk("hazir_start1", hazir1, 1);
        chk("top_start0", top0, 0);
        chk("top_start1", top1, 0);
    endtask

    task automatic drive(input logic [11:0] gs, input logic [3:0] s);
        sag_adimlar   = {gs[9:8], gs[5:4], gs[1:0]};
        asagi_adimlar = {gs[11:10], gs[7:6], gs[3:2]};
        sayi          = s;
    endtask

    task automatic round(input logic [11:0] gs, input logic [3:0] s,
                         input bit hold, input int k0, input int p,
                         input int t0, input int k1, input int t1);
        drive(gs, s);
        tur_gecerli = 1'b1;
        basla = hold;
        step();
        tur_gecerli = 1'b0;
        chk("pulse_early", sg0, 0);
        step();
        basla = 1'b0;
        chk("pulse0", sg0, 1);
        chk("pulse1", sg1, 1);
        chk("kazanan0", kaz0, k0);
        chk("kazanan1", kaz1, k1);
        chk("puan0", puan0, p);
        chk("puan1", puan1, p);
        chk("toplam0", top0, t0);
        chk("toplam1", top1, t1);
    endtask

    task automatic end_game(input int s0, input int s1);
        chk("bitti_early", bitti0, 0);
        step();
        chk("bitti0", bitti0, 1);
        chk("bitti1", bitti1, 1);
        chk("sampiyon0", samp0, s0);
        chk("sampiyon1", samp1, s1);
        chk("pulse_end", sg0, 0);
    endtask

    task automatic rnd_round(input bit hold);
        logic [3:0]  s;
        logic [11:0] gs;
        int k [2];
        int p;
        s = 4'($urandom_range(0, 15));
        for (int pl = 0; pl < 3; pl++)
            gs[(2-pl)*4 +: 4] = ($urandom_range(0, 2) == 0) ?
                                4'($urandom_range(0, 15)) : s;
        p = mscore(gs, int'(s));
        for (int d = 0; d < 2; d++) begin
            k[d] = mwin(mode[d], gs, int'(s));
            tot[d] = (tot[d] + p > cap[d]) ? cap[d] : tot[d] + p;
            if (k[d] != 0) wins[d][k[d]-1]++;
        end
        round(gs, s, hold, k[0], p, tot[0], k[1], tot[1]);
        rounds++;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{12'h663, 4'h6, 1, 9, 9, 1, 9};
        tbl[1] = '{12'h255, 4'h5, 3, 8, 17, 2, 15};
        tbl[2] = '{12'h123, 4'h9, 0, 0, 17, 0, 15};
        tbl[3] = '{12'hFF0, 4'hF, 1, 30, 47, 1, 15};

        #12;
        chk("rst_hazir", hazir0, 0);
        chk("rst_top", top0, 0);
        chk("rst_bitti", bitti0, 0);
        rst_n = 1'b1;
        step();
        chk("bosta_hazir", hazir0, 0);

        // Round offered in BOSTA together with basla: only basla acts.
        tur_gecerli = 1'b1;
        start();
        tur_gecerli = 1'b0;
        chk("no_accept_pulse", sg0, 0);

        for (int i = 0; i < 4; i++)
            round(tbl[i].gs, tbl[i].s, 1'b0, tbl[i].k0, tbl[i].p,
                  tbl[i].t0, tbl[i].k1, tbl[i].t1);
        end_game(1, 1);

        tur_gecerli = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bitti_hazir", hazir0, 0);
            chk("bitti_pulse", sg0, 0);
            chk("bitti_top", top0, 47);
        end
        start();
        tur_gecerli = 1'b0;
        chk("restart_bitti", bitti0, 0);
        chk("restart_samp", samp0, 0);
        chk("restart_kaz", kaz0, 0);
        chk("restart_puan", puan0, 0);

        for (int g = 0; g < 20; g++) begin
            if (g > 0) start();
            for (int r = 0; r < 4; r++) rnd_round(r == 1);
            end_game(mchamp(0), mchamp(1));
        end

        start();
        round(tbl[0].gs, tbl[0].s, 1'b0, 1, 9, 9, 1, 9);
        drive(tbl[3].gs, tbl[3].s);
        tur_gecerli = 1'b1;
        step();
        tur_gecerli = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_top0", top0, 0);
        chk("arst_top1", top1, 0);
        chk("arst_kaz", kaz0, 0);
        chk("arst_puan", puan0, 0);
        chk("arst_pulse", sg0, 0);
        chk("arst_hazir", hazir0, 0);
        #10;
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("post_rst_pulse", sg0, 0);
            chk("post_rst_hazir", hazir0, 0);
            chk("post_rst_top", top0, 0);
        end
        start();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
